redirect_unit: RTL and testbench
================================

# redirect_unit

Control-flow resolution block for the pipelined DLX core; produces the `branchCheck`, `JumpCheck` and `JRCheck` inputs that `control` consumes to flush IF/ID/EX. It samples the decoded `Branch`/`Jump`/`JR` flags plus ID-stage operands, resolves the branch condition and target, and pulses the matching check for exactly one cycle together with the redirect PC. It also ignores wrong-path decode during the flush cycle and keeps a saturating redirect counter.

## Interface

- `CNT_W`, default 16, width of `redirect_count`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID stage holds a real instruction; when low, all other ID inputs are don't-care (may be X).
- `Branch`, `Jump`, `JR`  in  1 each  decoded flags from `control`.
- `Opcode`  in  6  ID-stage opcode; selects the branch sense (0x04 BEQ, 0x05 BNEZ).
- `id_pc_plus4`  in  32  PC of the ID instruction + 4.
- `id_imm`  in  32  sign-extended 16-bit immediate.
- `id_joff`  in  26  J-type offset field.
- `rs_val`  in  32  forwarded rs operand.
- `branchCheck`, `JumpCheck`, `JRCheck`  out  1 each  registered one-cycle flush requests; at most one is high.
- `redirect_valid`  out  1  OR of the three checks.
- `redirect_pc`  out  32  new fetch PC; meaningful only while `redirect_valid` is high.
- `redirect_count`  out  `CNT_W`  number of redirects issued, saturating.

## Operation

- FSM states: IDLE, FLUSH. Reset state: IDLE.
- IDLE, rising edge, `id_valid`=1:
  - `JR`=1: take; target = `rs_val`; next cycle `JRCheck`=1.
  - else `Jump`=1: take; target = `id_pc_plus4` + sign-extend(`id_joff`); next cycle `JumpCheck`=1.
  - else `Branch`=1: Opcode 0x04 takes when `rs_val`==0; Opcode 0x05 takes when `rs_val`!=0; any other opcode is not taken. Target = `id_pc_plus4` + `id_imm`; next cycle `branchCheck`=1.
  - Priority is JR > Jump > Branch when flags overlap.
  - A taken instruction moves the FSM to FLUSH. A not-taken instruction, or `id_valid`=0, leaves it in IDLE with all checks low.
- FLUSH: the checks and `redirect_pc` stay stable for this cycle only. During FLUSH, `control` holds stale flag values, so all ID inputs are ignored. The FSM unconditionally returns to IDLE on the next edge.
- A flagged instruction present in ID during the FLUSH cycle is never evaluated, because it is wrong-path.
- Arithmetic: all additions are 32-bit modulo 2^32 with wrap-around and no overflow flag. `id_joff` is sign-extended from bit 25.
- `redirect_count` increments by 1 on each IDLE→FLUSH transition and saturates at 2^`CNT_W`−1.
- X-tolerance: when `id_valid`=0, X values on the flags or operands must not reach the outputs or the FSM state.

## Timing

- Latency: instruction sampled at edge N → check, `redirect_valid` and `redirect_pc` high during cycle N+1 → low from edge N+2.
- Maximum redirect rate is one every 2 cycles; back-to-back taken instructions are impossible by construction.
- Reset values: all checks 0, `redirect_valid` 0, `redirect_pc` 0, `redirect_count` 0, state IDLE.
- Reset asserted mid-FLUSH clears the checks immediately (asynchronously), without waiting for a clock edge. The first edge after `rst` deasserts samples inputs in IDLE.
- All outputs come straight from flops; there is no combinational path from any input to any output.

## Test plan

- BEQ taken: `Branch`=1, Opcode 0x04, `rs_val`=0, `id_pc_plus4`=0x100, `id_imm`=0xFFFFFFF8 → `branchCheck` high for exactly one cycle, `redirect_pc`=0xF8, `redirect_count`=1.
- BNEZ with `rs_val`=0, then BEQ with `rs_val`=5 → no check ever asserts and `redirect_count` stays 0.
- Jump with `id_joff`=0x3FFFFFC and `id_pc_plus4`=0x10 → `JumpCheck` pulse, `redirect_pc`=0x0C. Then JR with `rs_val`=0x2000 on the very next edge (during FLUSH) → ignored, with no second pulse.
- `JR`=1 and `Branch`=1 together with `rs_val`=0x40 → only `JRCheck` asserts, `redirect_pc`=0x40.
- `id_valid`=0 with all flags and operands driven to X for 10 cycles → outputs stay 0 with no X on any output. Then assert `rst` during a FLUSH cycle → checks drop within the same cycle.
- `CNT_W`=2: issue 5 taken jumps spaced 2 cycles apart → `redirect_count` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/redirect_unit.sv
// Resolves branch/jump/jump-register redirects from ID-stage operands and issues
// a registered one-cycle flush request with the new fetch PC and a saturating redirect count.
//
// state | meaning
// IDLE  | evaluating the ID instruction each edge
// FLUSH | redirect outputs held one cycle; ID inputs are wrong-path and ignored
module redirect_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             JR,
    input  logic [5:0]       Opcode,
    input  logic [31:0]      id_pc_plus4,
    input  logic [31:0]      id_imm,
    input  logic [25:0]      id_joff,
    input  logic [31:0]      rs_val,
    output logic             branchCheck,
    output logic             JumpCheck,
    output logic             JRCheck,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;

    state_t      state, state_nxt;
    logic        take_jr, take_j, take_b, take_any, cond;
    logic [31:0] target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Every decision is gated by id_valid, so unknown ID inputs never reach a flop
    always_comb begin
        state_nxt = IDLE;
        take_jr   = 1'b0;
        take_j    = 1'b0;
        take_b    = 1'b0;
        cond      = 1'b0;
        target    = redirect_pc;
        if (state == IDLE && id_valid) begin
            cond = (Opcode == OP_BEQ  && rs_val == 32'd0) ||
                   (Opcode == OP_BNEZ && rs_val != 32'd0);
            if (JR) begin
                take_jr = 1'b1;
                target  = rs_val;
            end else if (Jump) begin
                take_j = 1'b1;
                target = id_pc_plus4 + {{6{id_joff[25]}}, id_joff};
            end else if (Branch && cond) begin
                take_b = 1'b1;
                target = id_pc_plus4 + id_imm;
            end
        end
        take_any = take_jr | take_j | take_b;
        if (take_any) state_nxt = FLUSH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branchCheck    <= 1'b0;
            JumpCheck      <= 1'b0;
            JRCheck        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            redirect_count <= '0;
        end else begin
            branchCheck    <= take_b;
            JumpCheck      <= take_j;
            JRCheck        <= take_jr;
            redirect_valid <= take_any;
            if (take_any) redirect_pc <= target;
            if (take_any && redirect_count != {CNT_W{1'b1}})
                redirect_count <= redirect_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_redirect_unit.sv
// Self-checking bench for redirect_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the redirect rules.
module tb_redirect_unit;

    logic        clk, rst, id_valid, Branch, Jump, JR;
    logic [5:0]  Opcode;
    logic [31:0] id_pc_plus4, id_imm, rs_val;
    logic [25:0] id_joff;
    logic        b_chk, j_chk, jr_chk, r_valid, b_chk2, j_chk2, jr_chk2, r_valid2;
    logic [31:0] r_pc, r_pc2;
    logic [15:0] r_cnt;
    logic [1:0]  r_cnt2;

    int n_chk = 0;
    int n_pass = 0;

    // model expectations
    logic [2:0]  e_chk;   // {branch, jump, jr}
    logic [31:0] e_pc;
    int          e_cnt, e_cnt2;
    bit          m_flush;

    redirect_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .Branch(Branch), .Jump(Jump), .JR(JR),
        .Opcode(Opcode), .id_pc_plus4(id_pc_plus4), .id_imm(id_imm), .id_joff(id_joff),
        .rs_val(rs_val), .branchCheck(b_chk), .JumpCheck(j_chk), .JRCheck(jr_chk),
        .redirect_valid(r_valid), .redirect_pc(r_pc), .redirect_count(r_cnt)
    );

    redirect_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .Branch(Branch), .Jump(Jump), .JR(JR),
        .Opcode(Opcode), .id_pc_plus4(id_pc_plus4), .id_imm(id_imm), .id_joff(id_joff),
        .rs_val(rs_val), .branchCheck(b_chk2), .JumpCheck(j_chk2), .JRCheck(jr_chk2),
        .redirect_valid(r_valid2), .redirect_pc(r_pc2), .redirect_count(r_cnt2)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_flush = 0;
        e_chk   = 3'b000;
        e_pc    = 32'd0;
        e_cnt   = 0;
        e_cnt2  = 0;
    endtask

    // Drive one instruction, predict the outcome, advance one edge, settle.
    task automatic step(input logic v, input logic br, input logic jp, input logic jr,
                        input logic [5:0] op, input logic [31:0] p4, input logic [31:0] imm,
                        input logic [25:0] jo, input logic [31:0] rs);
        logic [31:0] joff_ext;
        id_valid = v; Branch = br; Jump = jp; JR = jr; Opcode = op;
        id_pc_plus4 = p4; id_imm = imm; id_joff = jo; rs_val = rs;
        e_chk = 3'b000;
        if (m_flush) begin
            m_flush = 0;
        end else if (v === 1'b1) begin
            joff_ext = {{6{jo[25]}}, jo};
            if (jr)                 begin e_chk = 3'b001; e_pc = rs; end
            else if (jp)            begin e_chk = 3'b010; e_pc = p4 + joff_ext; end
            else if (br && ((op == 6'h04 && rs == 0) || (op == 6'h05 && rs != 0)))
                                    begin e_chk = 3'b100; e_pc = p4 + imm; end
            if (e_chk != 3'b000) begin
                m_flush = 1;
                if (e_cnt < 65535) e_cnt++;
                if (e_cnt2 < 3) e_cnt2++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 6'h0, 32'h0, 32'h0, 26'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        #1;
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid, r_pc, r_cnt} !== 52'd0)
            $display("FAIL reset_outputs got %b %h %0d need all zero",
                     {b_chk, j_chk, jr_chk, r_valid}, r_pc, r_cnt);
        else n_pass++;
        n_chk++;
        if ({b_chk2, j_chk2, jr_chk2, r_valid2, r_cnt2} !== 6'd0)
            $display("FAIL reset_outputs_w2 got %b cnt %0d need zero",
                     {b_chk2, j_chk2, jr_chk2, r_valid2}, r_cnt2);
        else n_pass++;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_beq_taken();
        step(1, 1, 0, 0, 6'h04, 32'h100, 32'hFFFFFFF8, 26'h0, 32'h0);
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b1001 || r_pc !== 32'hF8 || r_cnt !== 16'd1)
            $display("FAIL beq_taken got %b pc %h cnt %0d need 1001 pc 000000f8 cnt 1",
                     {b_chk, j_chk, jr_chk, r_valid}, r_pc, r_cnt);
        else n_pass++;
        idle();
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0000)
            $display("FAIL beq_one_cycle got %b need 0000", {b_chk, j_chk, jr_chk, r_valid});
        else n_pass++;
    endtask

    task automatic test_not_taken();
        int c0;
        c0 = e_cnt;
        step(1, 1, 0, 0, 6'h05, 32'h200, 32'h10, 26'h0, 32'h0);
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0000 || r_cnt !== c0[15:0])
            $display("FAIL bnez_zero got %b cnt %0d need 0000 cnt %0d",
                     {b_chk, j_chk, jr_chk, r_valid}, r_cnt, c0);
        else n_pass++;
        step(1, 1, 0, 0, 6'h04, 32'h200, 32'h10, 26'h0, 32'h5);
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0000 || r_cnt !== c0[15:0])
            $display("FAIL beq_nonzero got %b cnt %0d need 0000 cnt %0d",
                     {b_chk, j_chk, jr_chk, r_valid}, r_cnt, c0);
        else n_pass++;
        step(1, 1, 0, 0, 6'h23, 32'h200, 32'h10, 26'h0, 32'h0);
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0000)
            $display("FAIL branch_other_opcode got %b need 0000", {b_chk, j_chk, jr_chk, r_valid});
        else n_pass++;
    endtask

    task automatic test_jump_then_jr();
        step(1, 0, 1, 0, 6'h02, 32'h10, 32'h0, 26'h3FFFFFC, 32'h0);
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0101 || r_pc !== 32'h0C)
            $display("FAIL jump_wrap got %b pc %h need 0101 pc 0000000c",
                     {b_chk, j_chk, jr_chk, r_valid}, r_pc);
        else n_pass++;
        step(1, 0, 0, 1, 6'h00, 32'h14, 32'h0, 26'h0, 32'h2000);
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0000)
            $display("FAIL jr_during_flush got %b need 0000", {b_chk, j_chk, jr_chk, r_valid});
        else n_pass++;
        idle();
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0000)
            $display("FAIL no_second_pulse got %b need 0000", {b_chk, j_chk, jr_chk, r_valid});
        else n_pass++;
    endtask

    task automatic test_priority();
        step(1, 1, 0, 1, 6'h05, 32'h300, 32'h80, 26'h0, 32'h40);
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0011 || r_pc !== 32'h40)
            $display("FAIL jr_priority got %b pc %h need 0011 pc 00000040",
                     {b_chk, j_chk, jr_chk, r_valid}, r_pc);
        else n_pass++;
        idle();
        step(1, 1, 1, 0, 6'h04, 32'h400, 32'h80, 26'h20, 32'h0);
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0101 || r_pc !== 32'h420)
            $display("FAIL jump_over_branch got %b pc %h need 0101 pc 00000420",
                     {b_chk, j_chk, jr_chk, r_valid}, r_pc);
        else n_pass++;
        idle();
    endtask

    task automatic test_x_idle_and_reset();
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 'x);
            if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0000 ||
                $isunknown({r_pc, r_cnt, r_cnt2, b_chk2, j_chk2, jr_chk2, r_valid2})) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL x_idle got %0d bad cycles need 0", bad);
        else n_pass++;
        step(1, 0, 1, 0, 6'h02, 32'h1000, 32'h0, 26'h8, 32'h0);
        n_chk++;
        if ({j_chk, r_valid} !== 2'b11 || r_pc !== 32'h1008)
            $display("FAIL pre_reset_jump got %b pc %h need 11 pc 00001008", {j_chk, r_valid}, r_pc);
        else n_pass++;
        #1 rst = 1;
        #1;
        n_chk++;
        if ({b_chk, j_chk, jr_chk, r_valid} !== 4'b0000 || r_cnt !== 16'd0 || r_pc !== 32'd0)
            $display("FAIL async_reset got %b pc %h cnt %0d need 0000 pc 0 cnt 0",
                     {b_chk, j_chk, jr_chk, r_valid}, r_pc, r_cnt);
        else n_pass++;
        #1 rst = 0;
        model_reset();
        step(1, 0, 0, 1, 6'h00, 32'h0, 32'h0, 26'h0, 32'h77);
        n_chk++;
        if ({jr_chk, r_valid} !== 2'b11 || r_pc !== 32'h77)
            $display("FAIL first_edge_after_reset got %b pc %h need 11 pc 00000077",
                     {jr_chk, r_valid}, r_pc);
        else n_pass++;
        idle();
    endtask

    task automatic test_saturate();
        logic [1:0] want [5];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
        rst = 1;
        #2 rst = 0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, 6'h02, 32'h40 * i, 32'h0, 26'h4, 32'h0);
            n_chk++;
            if (r_cnt2 !== want[i] || j_chk2 !== 1'b1)
                $display("FAIL saturate_%0d got cnt %0d chk %b need cnt %0d chk 1",
                         i, r_cnt2, j_chk2, want[i]);
            else n_pass++;
            idle();
        end
        n_chk++;
        if (r_cnt !== 16'd5)
            $display("FAIL wide_count got %0d need 5", r_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad;
        logic v, br, jp, jr;
        logic [5:0] op;
        logic [31:0] rs;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            br = $urandom_range(0, 1);
            jp = ($urandom_range(0, 3) == 0);
            jr = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 2))
                0:       op = 6'h04;
                1:       op = 6'h05;
                default: op = 6'($urandom);
            endcase
            rs = ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom;
            step(v, br, jp, jr, op, $urandom, $urandom, 26'($urandom), rs);
            if ({b_chk, j_chk, jr_chk} !== e_chk || r_valid !== (e_chk != 3'b000) ||
                r_cnt !== e_cnt[15:0] || r_cnt2 !== e_cnt2[1:0] ||
                (e_chk != 3'b000 && r_pc !== e_pc)) begin
                if (bad < 5)
                    $display("FAIL random_%0d got %b pc %h cnt %0d need %b pc %h cnt %0d",
                             i, {b_chk, j_chk, jr_chk}, r_pc, r_cnt, e_chk, e_pc, e_cnt);
                bad++;
            end
        end
        n_chk++;
        if (bad != 0) $display("FAIL random_total got %0d bad cycles need 0", bad);
        else n_pass++;
    endtask

    initial begin
        rst = 1;
        id_valid = 0; Branch = 0; Jump = 0; JR = 0; Opcode = 0;
        id_pc_plus4 = 0; id_imm = 0; id_joff = 0; rs_val = 0;
        model_reset();
        test_reset();
        test_beq_taken();
        test_not_taken();
        test_jump_then_jr();
        test_priority();
        test_x_idle_and_reset();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
